// File: rtl/collatz_sweep_ctrl.sv
// Sweeps the Collatz step-counter core over an inclusive seed range,
// launching one seed at a time and keeping the largest step count and its seed.
module collatz_sweep_ctrl #(
    parameter int unsigned NW          = 8,
    parameter int unsigned CW          = 8,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_go,
    input  logic [NW-1:0] i_n_first,
    input  logic [NW-1:0] i_n_last,
    output logic          o_core_start,
    output logic [NW-1:0] o_core_n,
    input  logic          i_core_busy,
    input  logic [CW-1:0] i_core_count,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_error,
    output logic [NW-1:0] o_cur_n,
    output logic [CW-1:0] o_max_count,
    output logic [NW-1:0] o_max_n
);

    localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0] TimerLast = TW'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StWaitAck,
        StWaitDone,
        StUpdate,
        StDone
    } state_t;

    state_t        r_state, w_state_next;
    logic [NW-1:0] r_n_last, w_n_last_next;
    logic [NW-1:0] r_cur_n, w_cur_n_next;
    logic [CW-1:0] r_max_count, w_max_count_next;
    logic [NW-1:0] r_max_n, w_max_n_next;
    logic [CW-1:0] r_count, w_count_next;
    logic          r_error, w_error_next;
    logic [TW-1:0] r_timer, w_timer_next;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_n_last    <= '0;
            r_cur_n     <= '0;
            r_max_count <= '0;
            r_max_n     <= '0;
            r_count     <= '0;
            r_error     <= 1'b0;
            r_timer     <= '0;
        end else begin
            r_state     <= w_state_next;
            r_n_last    <= w_n_last_next;
            r_cur_n     <= w_cur_n_next;
            r_max_count <= w_max_count_next;
            r_max_n     <= w_max_n_next;
            r_count     <= w_count_next;
            r_error     <= w_error_next;
            r_timer     <= w_timer_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_n_last_next    = r_n_last;
        w_cur_n_next     = r_cur_n;
        w_max_count_next = r_max_count;
        w_max_n_next     = r_max_n;
        w_count_next     = r_count;
        w_error_next     = r_error;
        w_timer_next     = r_timer;
        unique case (r_state)
            StIdle, StDone: begin
                if (i_go) begin
                    w_n_last_next    = i_n_last;
                    w_cur_n_next     = i_n_first;
                    w_max_count_next = '0;
                    w_max_n_next     = '0;
                    w_error_next     = 1'b0;
                    if (i_n_first == '0 || i_n_first > i_n_last) begin
                        w_error_next = 1'b1;
                        w_state_next = StDone;
                    end else begin
                        w_state_next = StLaunch;
                    end
                end
            end
            StLaunch: begin
                w_timer_next = '0;
                w_state_next = StWaitAck;
            end
            StWaitAck: begin
                if (i_core_busy) begin
                    w_state_next = StWaitDone;
                end else if (r_timer == TimerLast) begin
                    w_error_next = 1'b1;
                    w_state_next = StDone;
                end else begin
                    w_timer_next = r_timer + 1'b1;
                end
            end
            StWaitDone: begin
                if (!i_core_busy) begin
                    w_count_next = i_core_count;
                    w_state_next = StUpdate;
                end
            end
            StUpdate: begin
                // Strict compare keeps the lower seed on ties.
                if (r_count > r_max_count) begin
                    w_max_count_next = r_count;
                    w_max_n_next     = r_cur_n;
                end
                // Test before incrementing so a last seed of all-ones never wraps.
                if (r_cur_n == r_n_last) begin
                    w_state_next = StDone;
                end else begin
                    w_cur_n_next = r_cur_n + 1'b1;
                    w_state_next = StLaunch;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    assign o_core_start = (r_state == StLaunch);
    assign o_core_n     = r_cur_n;
    assign o_busy       = (r_state == StLaunch) || (r_state == StWaitAck) ||
                          (r_state == StWaitDone) || (r_state == StUpdate);
    assign o_done       = (r_state == StDone);
    assign o_error      = r_error;
    assign o_cur_n      = r_cur_n;
    assign o_max_count  = r_max_count;
    assign o_max_n      = r_max_n;

endmodule

// File: doc/collatz_sweep_ctrl.md
Name: collatz_sweep_ctrl

Overview:
- Sequencer that drives the Collatz step-counter core across an inclusive range of seeds and reduces its results.
- Issues one start per seed and waits for the core's busy handshake. Captures each step count and tracks the maximum count and the seed that produced it.
- Sits directly around the core: upstream, it supplies the seed and start; downstream, it consumes busy and the step count.
- Top-level test logic or a host reads the final max_count / max_n.

Parameters:
- NW, 8, seed width (matches core ui_in)
- CW, 8, step-count width (matches core uio_out)
- ACK_TIMEOUT, 15, cycles allowed between core_start and core_busy rising before the seed is declared failed

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- go  in  1  1-cycle request to start a sweep; ignored unless state is IDLE or DONE
- n_first  in  NW  first seed, sampled on accepted go
- n_last  in  NW  last seed (inclusive), sampled on accepted go
- core_start  out  1  start/enable pulse to core
- core_n  out  NW  seed to core; stable from core_start until the core's busy falls
- core_busy  in  1  core busy flag
- core_count  in  CW  core step count; valid when core_busy falls
- busy  out  1  high from accepted go until DONE
- done  out  1  high in DONE until next accepted go or rst
- error  out  1  sticky: bad range or ack timeout in this sweep
- cur_n  out  NW  seed currently or last processed
- max_count  out  CW  largest count seen in this sweep
- max_n  out  NW  seed that produced max_count

Behaviour:
- Reset: state=IDLE; all outputs 0.
- States: IDLE, LAUNCH, WAIT_ACK, WAIT_DONE, UPDATE, DONE.
- IDLE/DONE + go:
  - Latch n_first and n_last. Clear max_count, max_n, error and done. Set busy=1 and cur_n=n_first.
  - If n_first==0 or n_first>n_last: set error=1 and go to DONE next cycle. No core_start is issued.
  - Otherwise go to LAUNCH.
- LAUNCH:
  - core_n=cur_n and core_start=1 for exactly one cycle, the cycle after go. Then go to WAIT_ACK with the timeout counter cleared.
- WAIT_ACK:
  - core_busy==1 → WAIT_DONE.
  - Counter reaches ACK_TIMEOUT → error=1, then DONE. max fields keep their current values.
- WAIT_DONE:
  - On the first cycle with core_busy==0, capture core_count into an internal register, then go to UPDATE.
  - No timeout in this state; the core's own run length bounds it.
- UPDATE:
  - If captured count > max_count (strict), load max_count and max_n=cur_n. Ties keep the lower seed.
  - If cur_n==n_last → DONE. Otherwise cur_n+1 → LAUNCH.
  - The comparison against n_last happens before the increment, so n_last=255 never wraps to 0.
- DONE:
  - busy=0 and done=1. Outputs hold.
  - go restarts a sweep; go and rst in the same cycle: rst wins.
- go while busy: ignored, with no effect on the latched range.
- rst mid-sweep: core_start drops in the same edge and every output clears. A core left running is not waited on.
- Per-seed cadence: minimum 4 cycles plus the core run time. The first core_start comes 1 cycle after go.

Test Plan:
The bench uses a behavioural core: busy rises 1 cycle after start, and count is the number of steps until n reaches 1.
- rst, then go with n_first=1, n_last=10 → exactly 10 core_start pulses; done=1, max_count=19, max_n=9, error=0.
- go with 1..30 → max_count=111, max_n=27; cur_n=30 at done.
- Tie: go with 28..30 (all 18 steps) → max_count=18, max_n=28.
- Bad range: n_first=5, n_last=3, and separately n_first=0 → no core_start; done=1 and error=1 within 2 cycles; max fields 0.
- Timeout: core model never raises busy, range 3..3 → done=1 and error=1 exactly ACK_TIMEOUT cycles after WAIT_ACK entry.
- Robustness: go during a sweep is ignored; rst asserted during WAIT_DONE → next cycle all outputs 0. Then a new go with 255..255 completes with done=1, no wrap, and max_n=255.
